// File: rtl/mag_cmp_bist.sv
// Exhaustive self-test sequencer for a combinational WIDTH-bit magnitude comparator.
// Optional macro MAG_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module mag_cmp_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1      // legal range 1..15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic               c,
   input  logic               d,
   input  logic               e,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_cnt,
   output logic               fail_vld,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);

   localparam int IW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [3:0]       settle_q, settle_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [EW-1:0]    err_q, err_d;
   logic             fvld_q, fvld_d;
   logic [WIDTH-1:0] fa_q, fa_d;
   logic [WIDTH-1:0] fb_q, fb_d;
   logic             pass_q, pass_d;

   logic [2:0]       exp_flags;
   logic             mismatch;
   logic             last_vec;
   logic             finish;
   logic [EW-1:0]    err_inc;

   // Expectation is taken from the registered operands actually on the bus.
   assign exp_flags = {a_q > b_q, a_q == b_q, a_q < b_q};
   assign mismatch  = ({c, d, e} != exp_flags);
   assign last_vec  = (idx_q == {IW{1'b1}});
   assign err_inc   = (err_q == {EW{1'b1}}) ? err_q : err_q + EW'(1);

`ifdef MAG_BIST_STOP_ON_FAIL_EN
   assign finish = last_vec | mismatch;
`else
   assign finish = last_vec;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      a_d      = a_q;
      b_d      = b_q;
      err_d    = err_q;
      fvld_d   = fvld_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      pass_d   = pass_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = '0;
               err_d   = '0;
               fvld_d  = 1'b0;
               fa_d    = '0;
               fb_d    = '0;
               pass_d  = 1'b0;
            end
         end
         S_DRIVE: begin
            a_d      = idx_q[IW-1:WIDTH];
            b_d      = idx_q[WIDTH-1:0];
            settle_d = 4'(SETTLE);
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            // Leaving on the count of 1 gives exactly SETTLE cycles in WAIT.
            settle_d = settle_q - 4'd1;
            if (settle_q <= 4'd1) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               err_d = err_inc;
               if (!fvld_q) begin
                  fvld_d = 1'b1;
                  fa_d   = a_q;
                  fb_d   = b_q;
               end
            end
            if (finish) begin
               state_d = S_DONE;
               pass_d  = !mismatch && (err_q == '0);
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_DRIVE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         err_q    <= '0;
         fvld_q   <= 1'b0;
         fa_q     <= '0;
         fb_q     <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         a_q      <= a_d;
         b_q      <= b_d;
         err_q    <= err_d;
         fvld_q   <= fvld_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         pass_q   <= pass_d;
      end
   end

   assign a        = a_q;
   assign b        = b_q;
   assign busy     = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign done     = (state_q == S_DONE);
   assign pass     = pass_q;
   assign err_cnt  = err_q;
   assign fail_vld = fvld_q;
   assign fail_a   = fa_q;
   assign fail_b   = fb_q;

endmodule

// File: tb/tb_mag_cmp_bist.sv
// Self-checking bench for mag_cmp_bist: table of comparator fault models plus
// hand-written reset and held-start sequences; run results go through a queue.
module tb_mag_cmp_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a, b;
   logic       c, d, e;
   logic       busy, done, pass;
   logic [8:0] err_cnt;
   logic       fail_vld;
   logic [3:0] fail_a, fail_b;

   int mode = 0;   // 0 good, 1 d stuck at 0, 2 c/e swapped
   int errors = 0;
   int checks = 0;

   typedef struct {
      int mode;
      int cycles;
      int err;
      int pss;
      int fvld;
      int fa;
      int fb;
      int ea;
      int eb;
   } vec_t;

   vec_t tbl[4];
   vec_t exp_q[$];

   mag_cmp_bist #(.WIDTH(4), .SETTLE(1)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .fail_vld(fail_vld), .fail_a(fail_a), .fail_b(fail_b)
   );

   always #5 clk = ~clk;

   // Comparator model with injectable faults.
   always_comb begin
      c = (a > b);
      d = (a == b);
      e = (a < b);
      if (mode == 1) d = 1'b0;
      if (mode == 2) begin
         c = (a < b);
         e = (a > b);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic run_sweep(input vec_t v, input bit keep_start);
      vec_t ex;
      int cyc;
      mode  = v.mode;
      start = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
      if (!keep_start) start = 1'b0;
      chk("busy_rise", 32'(busy), 1);
      chk("done_clr", 32'(done), 0);
      chk("err_clr", 32'(err_cnt), 0);
      chk("pass_low", 32'(pass), 0);
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 4 && !done) chk("vec1_ab", 32'({a, b}), 32'h01);
         if (cyc == 52 && !done) chk("vec17_ab", 32'({a, b}), 32'h11);
      end
      ex = exp_q.pop_front();
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got busy=%0d expected done=1 within 2000 cycles", busy);
      end
      chk("done_edge", 32'(cyc), 32'(ex.cycles));
      chk("busy_fall", 32'(busy), 0);
      chk("err_cnt", 32'(err_cnt), 32'(ex.err));
      chk("pass", 32'(pass), 32'(ex.pss));
      chk("fail_vld", 32'(fail_vld), 32'(ex.fvld));
      chk("fail_a", 32'(fail_a), 32'(ex.fa));
      chk("fail_b", 32'(fail_b), 32'(ex.fb));
      chk("hold_a", 32'(a), 32'(ex.ea));
      chk("hold_b", 32'(b), 32'(ex.eb));
      $display("sweep mode=%0d edges=%0d err_cnt=%0d pass=%0d fail_vld=%0d fail=(%0d,%0d)",
               v.mode, cyc, err_cnt, pass, fail_vld, fail_a, fail_b);
   endtask

   initial begin
      // mode, cycles, err, pass, fvld, fa, fb, a, b
      tbl[0] = '{0, 768, 0, 1, 0, 0, 0, 15, 15};
`ifdef MAG_BIST_STOP_ON_FAIL_EN
      tbl[1] = '{1, 3, 1, 0, 1, 0, 0, 0, 0};
      tbl[2] = '{2, 6, 1, 0, 1, 0, 1, 0, 1};
`else
      tbl[1] = '{1, 768, 16, 0, 1, 0, 0, 15, 15};
      tbl[2] = '{2, 768, 240, 0, 1, 0, 1, 15, 15};
`endif
      tbl[3] = tbl[0];

      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ab", 32'({a, b}), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 0);

      for (int i = 0; i < 4; i++) run_sweep(tbl[i], 1'b0);

      // Reset mid-sweep.
      mode  = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (100) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_a", 32'(a), 0);
      chk("mid_rst_b", 32'(b), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_pass", 32'(pass), 0);
      chk("mid_rst_err", 32'(err_cnt), 0);
      chk("mid_rst_fvld", 32'(fail_vld), 0);
      chk("mid_rst_fa", 32'(fail_a), 0);
      chk("mid_rst_fb", 32'(fail_b), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", 32'({busy, done}), 0);
      run_sweep(tbl[0], 1'b0);

      // start held through a faulty sweep, then restart from DONE into a good one.
      run_sweep(tbl[2], 1'b1);
      chk("start_still_high", 32'(start), 1);
      run_sweep(tbl[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before 2000000");
      $fatal(1, "watchdog");
   end

endmodule
